// File: rtl/spart_pkg.sv
// Shared definitions for the SPART baud-rate-generator configuration controller:
// FSM state encoding, preset divisors and default limits.
package spart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK      = 3'd1,
        ST_WAIT_QUIET = 3'd2,
        ST_LOAD_HIGH  = 3'd3,
        ST_LOAD_LOW   = 3'd4,
        ST_SETTLE     = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    // Divisors for 4800 / 9600 / 19200 / 38400 baud
    localparam logic [15:0] DIV_4800  = 16'h0516;
    localparam logic [15:0] DIV_9600  = 16'h028B;
    localparam logic [15:0] DIV_19200 = 16'h0145;
    localparam logic [15:0] DIV_38400 = 16'h00A2;

    localparam int unsigned MIN_DIV_DEFAULT    = 16;
    localparam logic [16:0] SETTLE_MAX_DEFAULT = 17'd65540;

endpackage

// File: rtl/spart_baud_rom.sv
// Preset lookup: maps the 2-bit baud selector onto its 16-bit divisor.
module spart_baud_rom
    import spart_pkg::*;
(
    input  logic [1:0]  baud_sel_i,
    output logic [15:0] divisor_o
);

    always_comb begin
        divisor_o = DIV_4800;
        case (baud_sel_i)
            2'd0: divisor_o = DIV_4800;
            2'd1: divisor_o = DIV_9600;
            2'd2: divisor_o = DIV_19200;
            2'd3: divisor_o = DIV_38400;
            default: divisor_o = DIV_4800;
        endcase
    end

endmodule

// File: rtl/spart_brg_ctrl.sv
// Configuration sequencer for the SPART baud-rate generator: validates a divisor,
// waits for the serial engines to go quiet, loads it bytewise and waits for a tick.
module spart_brg_ctrl
    import spart_pkg::*;
#(
    parameter int unsigned MIN_DIV    = MIN_DIV_DEFAULT,
    parameter logic [16:0] SETTLE_MAX = SETTLE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic        cfg_use_preset,
    input  logic [1:0]  baud_sel,
    input  logic [15:0] cfg_divisor,
    input  logic        tx_busy,
    input  logic        rx_busy,
    input  logic        tx_enable,
    output logic        brg_load_high,
    output logic        brg_load_low,
    output logic [7:0]  brg_data,
    output logic        cfg_busy,
    output logic        cfg_ack,
    output logic        cfg_err,
    output logic        brg_valid
);

    localparam logic [15:0] MIN_DIV_W = MIN_DIV[15:0];

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [16:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        err_d, err_q;
    logic        load_high_d, load_high_q;
    logic        load_low_d, load_low_q;
    logic [7:0]  data_d, data_q;
    logic        busy_d, busy_q;
    logic        ack_d, ack_q;
    logic [15:0] rom_div;

    spart_baud_rom u_rom (
        .baud_sel_i (baud_sel),
        .divisor_o  (rom_div)
    );

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_req) begin
                    div_d   = cfg_use_preset ? rom_div : cfg_divisor;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (div_q < MIN_DIV_W) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT_QUIET;
                end
            end
            ST_WAIT_QUIET: begin
                if (!tx_busy && !rx_busy) begin
                    state_d = ST_LOAD_HIGH;
                    valid_d = 1'b0;
                end
            end
            ST_LOAD_HIGH: state_d = ST_LOAD_LOW;
            ST_LOAD_LOW: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 17'd1;
                // A tick on the last counted cycle still counts as success.
                if (tx_enable) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                end else if (cnt_q + 17'd1 == SETTLE_MAX) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        load_high_d = (state_d == ST_LOAD_HIGH);
        load_low_d  = (state_d == ST_LOAD_LOW);
        busy_d      = (state_d != ST_IDLE);
        ack_d       = (state_d == ST_DONE);
        data_d      = 8'h00;
        if (load_high_d) begin
            data_d = div_d[15:8];
        end else if (load_low_d) begin
            data_d = div_d[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            load_high_q <= 1'b0;
            load_low_q  <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            load_high_q <= load_high_d;
            load_low_q  <= load_low_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
        end
    end

    assign brg_load_high = load_high_q;
    assign brg_load_low  = load_low_q;
    assign brg_data      = data_q;
    assign cfg_busy      = busy_q;
    assign cfg_ack       = ack_q;
    assign cfg_err       = err_q;
    assign brg_valid     = valid_q;

endmodule

// File: doc/spart_brg_ctrl.md
SPART_BRG_CTRL -- requirements
Module: spart_brg_ctrl

Interface
REQ-001 Parameter MIN_DIV, default 16: smallest legal 16-bit divisor; smaller requests are rejected.
REQ-002 Parameter SETTLE_MAX, default 17'd65540: SETTLE timeout in clk cycles.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cfg_req  in  1  level request; sampled only in IDLE.
REQ-006 cfg_use_preset  in  1  1 selects the baud_sel preset; 0 selects cfg_divisor.
REQ-007 baud_sel  in  2  preset index: 0=4800, 1=9600, 2=19200, 3=38400.
REQ-008 cfg_divisor  in  16  explicit divisor {DBH,DBL}.
REQ-009 tx_busy, rx_busy  in  1 each  the serial engines are mid-frame.
REQ-010 tx_enable  in  1  baud tick from the divisor generator.
REQ-011 brg_load_high, brg_load_low  out  1 each  single-cycle load strobes.
REQ-012 brg_data  out  8  divisor byte presented with the strobes.
REQ-013 cfg_busy  out  1  high in every state except IDLE.
REQ-014 cfg_ack  out  1  one-cycle completion pulse.
REQ-015 cfg_err  out  1  valid only with cfg_ack: rejected request or settle timeout.
REQ-016 brg_valid  out  1  the generator holds a completed configuration.

Function
REQ-017 The FSM SHALL have the states IDLE, CHECK, WAIT_QUIET, LOAD_HIGH, LOAD_LOW, SETTLE and DONE; all outputs SHALL be registered.
REQ-018 IDLE: if cfg_req=1 at edge N, the controller SHALL latch the divisor (preset or explicit) and go to CHECK at N+1.
REQ-019 Preset divisors SHALL be 0x0516, 0x028B, 0x0145 and 0x00A2 for baud_sel 0 to 3.
REQ-020 CHECK: if the latched divisor is below MIN_DIV, go to DONE with cfg_err=1 and leave brg_valid unchanged; otherwise go to WAIT_QUIET.
REQ-021 WAIT_QUIET: stay while tx_busy or rx_busy is high; go to LOAD_HIGH on the first edge where both are low.
REQ-022 LOAD_HIGH: brg_load_high=1 and brg_data=div[15:8] for exactly one cycle.
REQ-023 LOAD_LOW: brg_load_low=1 and brg_data=div[7:0] for exactly one cycle; brg_valid SHALL clear on entry to LOAD_HIGH.
REQ-024 A strobe SHALL never coincide with the other strobe; brg_data SHALL be 0x00 when no strobe is active.
REQ-025 SETTLE: clear a 17-bit counter on entry and increment it each cycle.
  - tx_enable=1: go to DONE with cfg_err=0 and set brg_valid.
  - counter reaching SETTLE_MAX: go to DONE with cfg_err=1 and leave brg_valid low.
REQ-026 DONE: cfg_ack=1 for one cycle, then return to IDLE.
REQ-027 A new request SHALL NOT be accepted in the DONE cycle; cfg_req held high SHALL re-trigger from IDLE on the next edge.
REQ-028 Minimum latency with the engines quiet and a legal divisor:
  - request at edge N
  - brg_load_high at N+3
  - brg_load_low at N+4
  - cfg_ack one cycle after the first observed tx_enable.
REQ-029 Changes to cfg_divisor, baud_sel or cfg_use_preset after the request is accepted SHALL be ignored until the next IDLE.

Reset
REQ-030 While rst is high, the state SHALL be IDLE and every output and the counter SHALL be 0.
REQ-031 On the cycle rst deasserts, the outputs SHALL remain 0; no strobe SHALL appear because of the deassertion.
REQ-032 A reset in any state SHALL abort immediately with no partial strobe and no cfg_ack.

Structure
REQ-033 Package spart_pkg SHALL hold the FSM state enum, the four preset divisor constants and the default MIN_DIV.
REQ-034 Sub-module spart_baud_rom SHALL hold the preset lookup (baud_sel to 16-bit divisor); the FSM and counter stay in spart_brg_ctrl.

Verification
REQ-035 Preset 9600, engines idle: cfg_req=1, use_preset=1, baud_sel=1 -> load_high data 0x02, then load_low data 0x8B on the next cycle; after a tx_enable pulse, cfg_ack=1 with cfg_err=0 and brg_valid=1.
REQ-036 Explicit divisor 0x000F -> cfg_ack with cfg_err=1, no strobes, brg_valid unchanged.
REQ-037 tx_busy held high 50 cycles after the request -> no strobe until 1 cycle after tx_busy falls, then 0x00 and 0xA2 for divisor 0x00A2.
REQ-038 tx_enable held 0 in SETTLE -> cfg_ack with cfg_err=1 after 65540 cycles, brg_valid=0.
REQ-039 rst asserted the cycle after load_high -> all outputs 0 immediately, no load_low, state IDLE.
REQ-040 cfg_req held high across two completions -> two full sequences, with cfg_busy low for exactly one IDLE cycle between them.
